// File: rtl/sync_pkg.sv
// sync_pkg: shared types and constants for the sync pulse generator.
package sync_pkg;

  // Frame generator control states
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  // Reset-time frame configuration: 1 kHz frame, 1 us pulse at 33 MHz
  localparam int unsigned DEF_PERIOD  = 33000;
  localparam int unsigned DEF_WIDTH   = 33;

  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned BURST_W     = 16;

endpackage

// File: rtl/sync_channel.sv
// sync_channel: one output bit, high while delay <= phase < delay + width.
module sync_channel #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLOCK_33,
  input  logic             rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_phase,
  input  logic [CNT_W-1:0] i_p,
  input  logic [CNT_W-1:0] i_w,
  input  logic [CNT_W-1:0] i_delay,
  output logic             o_sync
);

  logic [CNT_W:0] w_end;
  logic           w_hit;
  logic           r_sync;

  // Pulse window; the end is formed one bit wider so delay + width cannot overflow
  always_comb begin
    w_end = {1'b0, i_delay} + {1'b0, i_w};
    w_hit = (i_delay < i_p) && (i_phase >= i_delay) && ({1'b0, i_phase} < w_end);
  end

  // Registered pulse output
  always_ff @(posedge CLOCK_33 or posedge rst) begin
    if (rst) begin
      r_sync <= 1'b0;
    end else begin
      r_sync <= i_en & w_hit;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/sync_pulse_gen.sv
// sync_pulse_gen: periodic frame generator with one programmable pulse per channel.
// Optional feature: define SYNC_BURST_EN to add burst_len/burst_done (auto stop after N frames).
module sync_pulse_gen
  import sync_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   CLOCK_33,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cfg_load,
  input  logic [CNT_W-1:0]       period,
  input  logic [CNT_W-1:0]       width,
  input  logic [N_CH*CNT_W-1:0]  delay,
`ifdef SYNC_BURST_EN
  input  logic [BURST_W-1:0]     burst_len,
  output logic                   burst_done,
`endif
  output logic [N_CH-1:0]        sync_out,
  output logic                   running,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned DLY_W = N_CH * CNT_W;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_start_q;
  logic                   r_stop_q;
  logic [CNT_W-1:0]       r_phase;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_running;

  logic [CNT_W-1:0]       r_per;
  logic [CNT_W-1:0]       r_wid;
  logic [DLY_W-1:0]       r_dly;
  logic [CNT_W-1:0]       r_pend_per;
  logic [CNT_W-1:0]       r_pend_wid;
  logic [DLY_W-1:0]       r_pend_dly;
  logic                   r_pend_vld;

  logic [CNT_W-1:0]       w_p;
  logic [CNT_W-1:0]       w_p_m1;
  logic [CNT_W-1:0]       w_w;
  logic                   w_active;
  logic                   w_wrap;
  logic                   w_burst_hit;
  logic                   w_frame_end;
  logic                   w_ch_en;

`ifdef SYNC_BURST_EN
  logic [BURST_W-1:0]     r_burst_len;
  logic [BURST_W-1:0]     r_pend_burst;
  logic [BURST_W-1:0]     r_burst_cnt;
  logic                   r_burst_done;
`endif

  // Effective period (at least 2) and width (at most P-1), frame wrap detect
  always_comb begin
    w_p      = (r_per < CNT_W'(2)) ? CNT_W'(2) : r_per;
    w_p_m1   = w_p - CNT_W'(1);
    w_w      = (r_wid > w_p_m1) ? w_p_m1 : r_wid;
    w_active = (r_state != S_IDLE);
    w_wrap   = w_active && (r_phase == w_p_m1);
  end

`ifdef SYNC_BURST_EN
  assign w_burst_hit = (r_state == S_RUN) && w_wrap && (r_burst_len != '0) &&
                       (BURST_W'(r_burst_cnt + BURST_W'(1)) == r_burst_len);
`else
  assign w_burst_hit = 1'b0;
`endif

  // Next-state logic; w_frame_end marks the wrap that returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_start_q && !r_stop_q) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_burst_hit) begin
          w_state_nxt = S_IDLE;
          w_frame_end = 1'b1;
        end else if (r_stop_q) begin
          w_state_nxt = S_STOPPING;
        end
      end
      S_STOPPING: begin
        if (w_wrap) begin
          w_state_nxt = S_IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_ch_en = w_active & ~w_frame_end;

  // State register
  always_ff @(posedge CLOCK_33 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request retiming: the frame starts one edge after the request is seen
  always_ff @(posedge CLOCK_33 or posedge rst) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_stop_q  <= 1'b0;
    end else begin
      r_start_q <= start;
      r_stop_q  <= stop;
    end
  end

  // Phase counter, completed-frame counter and running flag
  always_ff @(posedge CLOCK_33 or posedge rst) begin
    if (rst) begin
      r_phase     <= '0;
      r_frame_cnt <= '0;
      r_running   <= 1'b0;
    end else begin
      if (!w_active || w_wrap) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + CNT_W'(1);
      end
      if (w_wrap) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end
      r_running <= (w_state_nxt != S_IDLE);
    end
  end

  // Shadow/pending configuration: direct load when idle, otherwise only at a frame wrap
  always_ff @(posedge CLOCK_33 or posedge rst) begin
    if (rst) begin
      r_per      <= CNT_W'(DEF_PERIOD);
      r_wid      <= CNT_W'(DEF_WIDTH);
      r_dly      <= '0;
      r_pend_per <= '0;
      r_pend_wid <= '0;
      r_pend_dly <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      if (cfg_load && (!w_active || w_wrap)) begin
        r_per <= period;
        r_wid <= width;
        r_dly <= delay;
      end else if (w_wrap && r_pend_vld) begin
        r_per <= r_pend_per;
        r_wid <= r_pend_wid;
        r_dly <= r_pend_dly;
      end
      if (cfg_load && w_active && !w_wrap) begin
        r_pend_per <= period;
        r_pend_wid <= width;
        r_pend_dly <= delay;
        r_pend_vld <= 1'b1;
      end else if (w_wrap) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

`ifdef SYNC_BURST_EN
  // Burst length shadow, frames-in-run counter and termination pulse
  always_ff @(posedge CLOCK_33 or posedge rst) begin
    if (rst) begin
      r_burst_len  <= '0;
      r_pend_burst <= '0;
      r_burst_cnt  <= '0;
      r_burst_done <= 1'b0;
    end else begin
      if (cfg_load && (!w_active || w_wrap)) begin
        r_burst_len <= burst_len;
      end else if (w_wrap && r_pend_vld) begin
        r_burst_len <= r_pend_burst;
      end
      if (cfg_load && w_active && !w_wrap) begin
        r_pend_burst <= burst_len;
      end
      if (!w_active) begin
        r_burst_cnt <= '0;
      end else if (w_wrap) begin
        r_burst_cnt <= r_burst_cnt + BURST_W'(1);
      end
      r_burst_done <= w_burst_hit;
    end
  end

  assign burst_done = r_burst_done;
`endif

  // One comparator per channel
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    sync_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .CLOCK_33 (CLOCK_33),
      .rst      (rst),
      .i_en     (w_ch_en),
      .i_phase  (r_phase),
      .i_p      (w_p),
      .i_w      (w_w),
      .i_delay  (r_dly[gi*CNT_W +: CNT_W]),
      .o_sync   (sync_out[gi])
    );
  end

  assign running   = r_running;
  assign frame_cnt = r_frame_cnt;

endmodule
